// File: rtl/ibert_axis_feeder.sv
// Purpose : cuts an unframed 32-bit source stream into the accelerator's segment order, with TLAST on segment ends.
// Latency : 1 cycle from source accept to x_* valid; a 1-cycle bubble follows every segment end.
// Backpr. : src_TREADY follows a free/draining output register; capture pauses until the segment-end word is taken.
//
// Ports:
//   clk, rst_n (synchronous, active-low)        start/busy/done    : run control
//   src_TDATA/TVALID/TLAST/TREADY               : raw source stream
//   x_TDATA/TVALID/TLAST/TREADY                 : segmented accelerator input stream
//   phase (0 idle, 1 input, 2 head, 3 self, 4 inter, 5 layer), layer, err
// Optional: define IBERT_FEED_CHK_EN to compare src_TLAST against the computed
//   segment end and raise a sticky err; otherwise src_TLAST is ignored and err is 0.
// LAYERS must be at least 2 so that the layer port has a non-zero width.

module ibert_axis_feeder #(
    parameter int LAYERS    = 12,
    parameter int HEADS     = 12,
    parameter int SLICES    = 8,
    parameter int CNT_W     = 24,
    parameter int SEG_I     = 24576,
    parameter int SEG_HEAD  = 1,
    parameter int SEG_SELF  = 1,
    parameter int SEG_INTER = 1,
    parameter int SEG_LAYER = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [31:0]               src_TDATA,
    input  logic                      src_TVALID,
    input  logic                      src_TLAST,
    output logic                      src_TREADY,
    output logic [31:0]               x_TDATA,
    output logic                      x_TVALID,
    output logic                      x_TLAST,
    input  logic                      x_TREADY,
    output logic [2:0]                phase,
    output logic [$clog2(LAYERS)-1:0] layer,
    output logic                      err
);

    localparam int LW = $clog2(LAYERS);
    localparam int HW = (HEADS  > 1) ? $clog2(HEADS)  : 1;
    localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [CNT_W-1:0] LAST_I     = CNT_W'(SEG_I - 1);
    localparam logic [CNT_W-1:0] LAST_HEAD  = CNT_W'(SEG_HEAD - 1);
    localparam logic [CNT_W-1:0] LAST_SELF  = CNT_W'(SEG_SELF - 1);
    localparam logic [CNT_W-1:0] LAST_INTER = CNT_W'(SEG_INTER - 1);
    localparam logic [CNT_W-1:0] LAST_LAYER = CNT_W'(SEG_LAYER - 1);

    // Encodings 1..5 double as the phase output value.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INPUT = 3'd1,
        S_HEAD  = 3'd2,
        S_SELF  = 3'd3,
        S_INTER = 3'd4,
        S_LAYER = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     head_q, head_d;
    logic [SW-1:0]     slice_q, slice_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [CNT_W-1:0]  word_q;
    logic [CNT_W-1:0]  seg_last;
    logic              seg_pend_q;
    logic              xv_q, xl_q;
    logic [31:0]       xd_q;
    logic              err_q;

    logic active, src_rdy, src_acc, word_last, x_acc_last;

    assign active     = (state_q inside {S_INPUT, S_HEAD, S_SELF, S_INTER, S_LAYER});
    // Capture only when the output register is free or draining this cycle, and
    // never while a segment-end word is still waiting to be taken downstream.
    assign src_rdy    = active & (~xv_q | x_TREADY) & ~seg_pend_q;
    assign src_acc    = src_TVALID & src_rdy;
    assign word_last  = (word_q == seg_last);
    assign x_acc_last = xv_q & x_TREADY & xl_q;

    always_comb begin
        seg_last = '0;
        case (state_q)
            S_INPUT: seg_last = LAST_I;
            S_HEAD:  seg_last = LAST_HEAD;
            S_SELF:  seg_last = LAST_SELF;
            S_INTER: seg_last = LAST_INTER;
            S_LAYER: seg_last = LAST_LAYER;
            default: seg_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            slice_q <= '0;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            slice_q <= slice_d;
            layer_q <= layer_d;
        end
    end

    // Sequencing advances only when a segment-end word leaves the output register.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        slice_d = slice_q;
        layer_d = layer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INPUT;
                    head_d  = '0;
                    slice_d = '0;
                    layer_d = '0;
                end
            end
            S_INPUT: begin
                if (x_acc_last) begin
                    state_d = S_HEAD;
                    head_d  = '0;
                end
            end
            S_HEAD: begin
                if (x_acc_last) begin
                    if (head_q == HW'(HEADS - 1)) begin
                        state_d = S_SELF;
                        head_d  = '0;
                    end else begin
                        head_d  = head_q + HW'(1);
                    end
                end
            end
            S_SELF:  if (x_acc_last) state_d = S_INTER;
            S_INTER: if (x_acc_last) state_d = S_LAYER;
            S_LAYER: begin
                if (x_acc_last) begin
                    if (slice_q < SW'(SLICES - 1)) begin
                        slice_d = slice_q + SW'(1);
                        state_d = S_SELF;
                    end else begin
                        slice_d = '0;
                        if (layer_q == LW'(LAYERS - 1)) begin
                            layer_d = '0;
                            state_d = S_DONE;
                        end else begin
                            layer_d = layer_q + LW'(1);
                            state_d = S_HEAD;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q     <= '0;
            seg_pend_q <= 1'b0;
            xv_q       <= 1'b0;
            xl_q       <= 1'b0;
            xd_q       <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                word_q <= '0;
            end
            if (src_acc) begin
                xd_q   <= src_TDATA;
                xv_q   <= 1'b1;
                xl_q   <= word_last;
                word_q <= word_last ? '0 : word_q + CNT_W'(1);
            end else if (xv_q && x_TREADY) begin
                xv_q <= 1'b0;
                xl_q <= 1'b0;
            end
            // Set and clear are mutually exclusive: capture is blocked while pending.
            if (x_acc_last) begin
                seg_pend_q <= 1'b0;
            end
            if (src_acc && word_last) begin
                seg_pend_q <= 1'b1;
            end
        end
    end

`ifdef IBERT_FEED_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (src_acc && (src_TLAST != word_last)) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_src_tlast;
    assign unused_src_tlast = src_TLAST;
    assign err_q            = 1'b0;
`endif

    // Outputs are forced quiet during any reset cycle, not just after the reset edge.
    assign busy       = rst_n & active;
    assign done       = rst_n & (state_q == S_DONE);
    assign src_TREADY = rst_n & src_rdy;
    assign x_TVALID   = rst_n & xv_q;
    assign x_TLAST    = rst_n & xl_q;
    assign x_TDATA    = rst_n ? xd_q : 32'd0;
    assign phase      = (rst_n && active) ? 3'(state_q) : 3'd0;
    assign layer      = rst_n ? layer_q : '0;
    assign err        = rst_n & err_q;

endmodule
